avalon_rr_arbiter: RTL and testbench
====================================

// Module: avalon_rr_arbiter
// PURPOSE
//  Two-master round-robin arbiter sharing the single DDR3 controller Avalon-MM port (avl_*).
//  Sits between two traffic sources (test driver, video/DMA engine) and the UniPHY local interface.
//  Holds the grant for whole write bursts and tags every read command. Returned read beats are
//  routed back to the issuing master in order.
// PARAMETERS
//  ADDR_W    26   Avalon word address width
//  DATA_W    128  Avalon data width
//  SIZE_W    8    burst-count (avl_size) width
//  OUTST_D   16   depth of outstanding-read tag FIFO (power of 2)
// PORTS (mN_* exists for N=0 and N=1)
//  iCLK             in   1       controller user clock
//  iRST_n           in   1       async active-low reset
//  mN_address       in   ADDR_W  master N address
//  mN_writedata     in   DATA_W  master N write data
//  mN_read/mN_write in   1       master N command strobes (never both high)
//  mN_size          in   SIZE_W  master N burst length, 0 treated as 1
//  mN_waitrequest   out  1       stall to master N
//  mN_readdata      out  DATA_W  avl_readdata, broadcast
//  mN_readdatavalid out  1       read beat belongs to master N
//  avl_address      out  ADDR_W  to controller
//  avl_writedata    out  DATA_W  to controller
//  avl_read/avl_write out 1      to controller
//  avl_burstbegin   out  1       first beat of each command
//  avl_size         out  SIZE_W  burst length of the granted command
//  avl_waitrequest  in   1       controller stall
//  avl_readdata     in   DATA_W  controller read data
//  avl_readdatavalid in  1       controller read beat valid
//  grant_id         out  1       currently or last granted master
//  err_orphan       out  1       sticky: readdatavalid seen with tag FIFO empty
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (master 0 wins the first tie), FIFO empty, beat_cnt=0.
//   All avl_* and mN_readdatavalid are 0, both mN_waitrequest are 1, grant_id=0, err_orphan=0.
//  FSM IDLE -> BUSY -> IDLE. Nothing is forwarded in IDLE; both masters see waitrequest=1.
//   IDLE: req_N = mN_read|mN_write.
//   - If only one master requests, that master is granted.
//   - If both request, the master != last_grant is granted.
//   - The grant registers into grant_id and the FSM enters BUSY on the next edge.
//   - Arbitration latency is therefore 1 cycle.
//  BUSY datapath: the granted master's signals are muxed onto avl_*.
//   - avl_waitrequest is passed to the granted master.
//   - The other master is held with waitrequest=1.
//  Beat accepted = (avl_read|avl_write) & !avl_waitrequest.
//  Write burst: beat_cnt counts accepted beats.
//   - The size is latched on the first beat.
//   - On the final accepted beat: last_grant<=grant_id, beat_cnt<=0, FSM -> IDLE.
//   - The grant is never dropped mid-burst, even if the master idles between beats.
//  Read: one accepted command pushes {grant_id,size} into the tag FIFO, then the FSM -> IDLE.
//  Tag FIFO full: avl_read is forced 0 and the master is held with waitrequest=1 until a pop frees
//   an entry. Push while full is never done; pop and push in the same cycle are both allowed when
//   the FIFO is not full.
//  Granted master drops its request with beat_cnt==0 (nothing accepted): FSM -> IDLE and
//   last_grant is not updated.
//  avl_burstbegin = BUSY & beat_cnt==0 & (avl_read|avl_write). It stays high while stalled.
//  Read return:
//   - mN_readdatavalid = avl_readdatavalid & FIFO non-empty & head.id==N. This is combinational,
//     with zero added latency.
//   - A head down-counter is loaded from head.size. The entry is popped on the beat where the
//     count reaches 1.
//   - avl_readdatavalid with the FIFO empty: no master valid, and err_orphan<=1 (sticky until reset).
//  Reset mid-burst or with reads outstanding: all state is cleared immediately; in-flight beats
//   after reset count as orphans.
// TESTING
//  m0 writes 1 beat at 0x10 with no contention -> grant 1 cycle after the request;
//   avl_write+burstbegin with addr 0x10; m1_waitrequest=1 throughout.
//  m0 and m1 request writes in the same cycle after reset -> m0 served first, then m1; with both
//   held continuously, grants alternate 0,1,0,1.
//  m1 write size=4, avl_waitrequest toggled every other cycle -> exactly 4 beats accepted, m0
//   locked out until the 4th beat; burstbegin only before the 1st acceptance.
//  m0 reads size=2 at 0x0, then m1 reads size=1 at 0x8, controller returns 3 beats -> m0 valid on
//   beats 1-2, m1 valid on beat 3; FIFO empty afterwards.
//  17 single-beat reads issued with no data returned (OUTST_D=16) -> the 17th is held, avl_read=0;
//   it is accepted the cycle after the first return beat pops.
//  avl_readdatavalid pulsed with the FIFO empty -> err_orphan=1 and both mN_readdatavalid=0;
//   iRST_n low clears err_orphan.

Source files
------------

// File: rtl/avalon_rr_arbiter.sv
// Two-master round-robin arbiter onto one Avalon-MM DDR3 port; read beats routed back by tag FIFO.
// Latency: 1-cycle arbitration, then commands forwarded combinationally; read return adds 0 cycles.
// Backpressure: avl_waitrequest passed to the granted master; the other master and full-FIFO reads stall.

module avalon_rr_arbiter_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & ~empty;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module avalon_rr_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 128,
    parameter int SIZE_W  = 8,
    parameter int OUTST_D = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [SIZE_W-1:0] m0_size,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [SIZE_W-1:0] m1_size,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_read,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic [SIZE_W-1:0] avl_size,
    input  logic              avl_waitrequest,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,
    output logic              grant_id,
    output logic              err_orphan
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic              id;
        logic [SIZE_W-1:0] size;
    } tag_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              arb_pick;
    logic              req0;
    logic              req1;
    logic [SIZE_W-1:0] beat_cnt;
    logic [SIZE_W-1:0] burst_len;
    logic [SIZE_W-1:0] cur_len;
    logic [SIZE_W-1:0] rd_rem;
    logic [SIZE_W-1:0] cur_rem;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SIZE_W-1:0] sel_size;
    logic [SIZE_W-1:0] sel_size_eff;
    logic              accept;
    logic              last_beat;
    logic              rd_done;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              ret_beat;
    tag_t              push_tag;
    tag_t              head_tag;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    // On a tie the master that did not win last time goes next.
    assign arb_pick = (req0 & req1) ? ~last_grant : req1;

    assign sel_read     = grant_id ? m1_read      : m0_read;
    assign sel_write    = grant_id ? m1_write     : m0_write;
    assign sel_addr     = grant_id ? m1_address   : m0_address;
    assign sel_wdata    = grant_id ? m1_writedata : m0_writedata;
    assign sel_size     = grant_id ? m1_size      : m0_size;
    assign sel_size_eff = (sel_size == '0) ? SIZE_W'(1) : sel_size;

    assign accept    = (avl_read | avl_write) & ~avl_waitrequest;
    assign cur_len   = (beat_cnt == '0) ? sel_size_eff : burst_len;
    assign last_beat = accept & avl_write & (({1'b0, beat_cnt} + 1'b1) == {1'b0, cur_len});
    assign rd_done   = accept & avl_read;
    assign drop      = (state == BUSY) & (beat_cnt == '0) & ~sel_read & ~sel_write;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 | req1) state_nxt = BUSY;
            BUSY:    if (last_beat | rd_done | drop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_address    = '0;
        avl_writedata  = '0;
        avl_size       = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state == BUSY) begin
            avl_read      = sel_read & ~fifo_full;
            avl_write     = sel_write;
            avl_address   = sel_addr;
            avl_writedata = sel_wdata;
            avl_size      = sel_size_eff;
            if (grant_id) m1_waitrequest = avl_waitrequest | (sel_read & fifo_full);
            else          m0_waitrequest = avl_waitrequest | (sel_read & fifo_full);
        end
        avl_burstbegin = (state == BUSY) & (beat_cnt == '0) & (avl_read | avl_write);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            burst_len  <= '0;
        end else begin
            if (state == IDLE && (req0 | req1)) grant_id <= arb_pick;
            if (last_beat) begin
                beat_cnt   <= '0;
                last_grant <= grant_id;
            end else if (accept && avl_write) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == '0) burst_len <= sel_size_eff;
            end
            if (rd_done) last_grant <= grant_id;
        end
    end

    assign push_tag = '{id: grant_id, size: sel_size_eff};

    avalon_rr_arbiter_fifo #(
        .W     ($bits(tag_t)),
        .DEPTH (OUTST_D)
    ) u_tag_fifo (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .push_vld (rd_done),
        .push_dat (push_tag),
        .pop_rdy  (fifo_pop),
        .head_dat (head_tag),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // rd_rem==0 means the head entry has not returned any beat yet.
    assign ret_beat = avl_readdatavalid & ~fifo_empty;
    assign cur_rem  = (rd_rem == '0) ? head_tag.size : rd_rem;
    assign fifo_pop = ret_beat & (cur_rem == SIZE_W'(1));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_rem     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (ret_beat) rd_rem <= fifo_pop ? '0 : cur_rem - 1'b1;
            if (avl_readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign m0_readdata      = avl_readdata;
    assign m1_readdata      = avl_readdata;
    assign m0_readdatavalid = ret_beat & (head_tag.id == 1'b0);
    assign m1_readdatavalid = ret_beat & (head_tag.id == 1'b1);
endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Bench for avalon_rr_arbiter: directed master/controller stimulus, expected commands and
// read-return routing queued at issue time and checked by an independent monitor.

module tb_avalon_rr_arbiter;
    typedef struct packed {
        logic        rd;
        logic        gid;
        logic [25:0] addr;
        logic        bb;
        logic [7:0]  size;
    } cmd_t;

    logic         iCLK;
    logic         iRST_n;
    logic [25:0]  m0_address, m1_address;
    logic [127:0] m0_writedata, m1_writedata;
    logic         m0_read, m0_write, m1_read, m1_write;
    logic [7:0]   m0_size, m1_size;
    logic         m0_waitrequest, m1_waitrequest;
    logic [127:0] m0_readdata, m1_readdata;
    logic         m0_readdatavalid, m1_readdatavalid;
    logic [25:0]  avl_address;
    logic [127:0] avl_writedata;
    logic         avl_read, avl_write, avl_burstbegin;
    logic [7:0]   avl_size;
    logic         avl_waitrequest;
    logic [127:0] avl_readdata;
    logic         avl_readdatavalid;
    logic         grant_id;
    logic         err_orphan;

    int   checks = 0;
    int   errors = 0;
    cmd_t cmd_q[$];
    logic [1:0] ret_q[$];
    cmd_t mon_cmd;
    logic [1:0] mon_ret;
    bit   done17;

    avalon_rr_arbiter dut (
        .iCLK              (iCLK),
        .iRST_n            (iRST_n),
        .m0_address        (m0_address),
        .m0_writedata      (m0_writedata),
        .m0_read           (m0_read),
        .m0_write          (m0_write),
        .m0_size           (m0_size),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdata       (m0_readdata),
        .m0_readdatavalid  (m0_readdatavalid),
        .m1_address        (m1_address),
        .m1_writedata      (m1_writedata),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_size           (m1_size),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdata       (m1_readdata),
        .m1_readdatavalid  (m1_readdatavalid),
        .avl_address       (avl_address),
        .avl_writedata     (avl_writedata),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_burstbegin    (avl_burstbegin),
        .avl_size          (avl_size),
        .avl_waitrequest   (avl_waitrequest),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .grant_id          (grant_id),
        .err_orphan        (err_orphan)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic rd, input logic gid, input logic [25:0] a,
                                input logic bb, input logic [7:0] s);
        cmd_t c;
        c.rd = rd; c.gid = gid; c.addr = a; c.bb = bb; c.size = s;
        return c;
    endfunction

    task automatic drive(input int m, input logic rd, input logic wr, input logic [25:0] a,
                         input logic [7:0] s, input logic [127:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_size = s; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_size = s; m1_writedata = d;
        end
    endtask

    // Issues one command from master m; returns stall cycles before the first accepted beat.
    task automatic mcmd(input int m, input logic rd, input logic [25:0] a, input logic [7:0] s,
                        output int wait_cyc, output bit other_low);
        int n;
        int beats;
        int guard;
        n = rd ? 1 : ((s == 8'd0) ? 1 : int'(s));
        beats = 0; guard = 0; wait_cyc = 0; other_low = 1'b0;
        while (beats < n && guard < 400) begin
            drive(m, rd, !rd, a, s, {96'h0, 32'(beats)});
            @(negedge iCLK);
            guard++;
            if (m == 0 ? !m1_waitrequest : !m0_waitrequest) other_low = 1'b1;
            if (m == 0 ? !m0_waitrequest : !m1_waitrequest) beats++;
            else if (beats == 0) wait_cyc++;
            @(posedge iCLK); #1;
        end
        drive(m, 1'b0, 1'b0, 26'h0, 8'h0, 128'h0);
        check($sformatf("m%0d_beats_accepted", m), 64'(beats), 64'(n));
    endtask

    task automatic ret_beats(input int n);
        for (int i = 0; i < n; i++) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = 128'(i + 1);
            @(posedge iCLK); #1;
        end
        avl_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        @(negedge iCLK);
        check("rst_avl_write", avl_write, 0);
        check("rst_avl_read", avl_read, 0);
        check("rst_burstbegin", avl_burstbegin, 0);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_grant_id", grant_id, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        @(posedge iCLK); #1;
        iRST_n = 1'b1;
    endtask

    always @(negedge iCLK) begin
        if (iRST_n) begin
            if ((avl_read | avl_write) && !avl_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check("cmd_rd", avl_read, mon_cmd.rd);
                    check("cmd_wr", avl_write, !mon_cmd.rd);
                    check("cmd_gid", grant_id, mon_cmd.gid);
                    check("cmd_addr", avl_address, mon_cmd.addr);
                    check("cmd_bb", avl_burstbegin, mon_cmd.bb);
                    check("cmd_size", avl_size, mon_cmd.size);
                end
            end
            if (avl_readdatavalid) begin
                if (ret_q.size() == 0) begin
                    check("ret_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_ret = ret_q.pop_front();
                    check("ret_route", {m0_readdatavalid, m1_readdatavalid}, mon_ret);
                end
            end else if (m0_readdatavalid || m1_readdatavalid) begin
                check("rdv_spurious", {m0_readdatavalid, m1_readdatavalid}, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0, w1;
        bit  o0, o1;
        int  k;
        iRST_n = 1'b1;
        drive(0, 1'b0, 1'b0, 26'h0, 8'h0, 128'h0);
        drive(1, 1'b0, 1'b0, 26'h0, 8'h0, 128'h0);
        avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0; avl_readdata = '0;
        done17 = 1'b0;
        #2;
        do_reset();

        // Single uncontended write
        cmd_q.push_back(mk(1'b0, 1'b0, 26'h10, 1'b1, 8'd1));
        mcmd(0, 1'b0, 26'h10, 8'd1, w0, o0);
        check("t1_grant_latency", 64'(w0), 64'd1);
        check("t1_m1_held", 64'(o0), 64'd0);

        // Simultaneous requests after reset, both held: 0,1,0,1
        do_reset();
        cmd_q.push_back(mk(1'b0, 1'b0, 26'h100, 1'b1, 8'd1));
        cmd_q.push_back(mk(1'b0, 1'b1, 26'h200, 1'b1, 8'd1));
        cmd_q.push_back(mk(1'b0, 1'b0, 26'h101, 1'b1, 8'd1));
        cmd_q.push_back(mk(1'b0, 1'b1, 26'h201, 1'b1, 8'd1));
        fork
            begin
                mcmd(0, 1'b0, 26'h100, 8'd1, w0, o0);
                check("t2_m0_first_wait", 64'(w0), 64'd1);
                mcmd(0, 1'b0, 26'h101, 8'd1, w0, o0);
            end
            begin
                mcmd(1, 1'b0, 26'h200, 8'd1, w1, o1);
                check("t2_m1_first_wait", 64'(w1), 64'd3);
                mcmd(1, 1'b0, 26'h201, 8'd1, w1, o1);
            end
        join

        // m1 4-beat burst under toggling waitrequest, m0 locked out
        for (int i = 0; i < 4; i++) cmd_q.push_back(mk(1'b0, 1'b1, 26'h300, (i == 0), 8'd4));
        cmd_q.push_back(mk(1'b0, 1'b0, 26'h400, 1'b1, 8'd1));
        fork
            mcmd(1, 1'b0, 26'h300, 8'd4, w1, o1);
            begin
                @(posedge iCLK); #1;
                mcmd(0, 1'b0, 26'h400, 8'd1, w0, o0);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    @(posedge iCLK); #1;
                    avl_waitrequest = ~avl_waitrequest;
                end
                avl_waitrequest = 1'b0;
            end
        join

        // Two reads, returned beats routed in issue order
        cmd_q.push_back(mk(1'b1, 1'b0, 26'h0, 1'b1, 8'd2));
        cmd_q.push_back(mk(1'b1, 1'b1, 26'h8, 1'b1, 8'd1));
        mcmd(0, 1'b1, 26'h0, 8'd2, w0, o0);
        mcmd(1, 1'b1, 26'h8, 8'd1, w1, o1);
        ret_q.push_back(2'b10);
        ret_q.push_back(2'b10);
        ret_q.push_back(2'b01);
        ret_beats(3);
        check("t4_no_orphan", err_orphan, 0);

        // Fill the tag FIFO; the 17th read waits for a pop
        for (int i = 0; i < 17; i++) cmd_q.push_back(mk(1'b1, 1'b0, 26'(i), 1'b1, 8'd1));
        for (int i = 0; i < 16; i++) mcmd(0, 1'b1, 26'(i), 8'd1, w0, o0);
        fork
            begin
                mcmd(0, 1'b1, 26'd16, 8'd1, w0, o0);
                done17 = 1'b1;
            end
        join_none
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            check("t5_held_avl_read", avl_read, 0);
            check("t5_held_m0_wait", m0_waitrequest, 1);
        end
        @(posedge iCLK); #1;
        ret_q.push_back(2'b10);
        ret_beats(1);
        @(negedge iCLK);
        check("t5_after_pop_avl_read", avl_read, 1);
        check("t5_after_pop_m0_wait", m0_waitrequest, 0);
        @(posedge iCLK); #1;
        k = 0;
        while (!done17 && k < 50) begin
            @(posedge iCLK); #1;
            k++;
        end
        check("t5_17th_done", done17, 1);
        for (int i = 0; i < 16; i++) ret_q.push_back(2'b10);
        ret_beats(16);

        // Orphan beat with FIFO empty
        @(negedge iCLK);
        check("t6_pre_orphan", err_orphan, 0);
        @(posedge iCLK); #1;
        ret_q.push_back(2'b00);
        ret_beats(1);
        @(negedge iCLK);
        check("t6_err_orphan_set", err_orphan, 1);
        @(negedge iCLK);
        check("t6_err_orphan_sticky", err_orphan, 1);
        do_reset();

        repeat (3) @(posedge iCLK);
        check("cmd_q_left", 64'(cmd_q.size()), 64'd0);
        check("ret_q_left", 64'(ret_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
